// File: rtl/wallace_mac_sequencer.sv
// Multiply-accumulate job sequencer that feeds an external 8x8 Wallace tree multiplier.
// It accepts len operand pairs per job, accumulates the products and hands the sum over with a valid/ready handshake.
module wallace_mac_sequencer #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [15:0]      mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic             p_vld;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic             xfer;
    logic [ACC_W:0]   acc_sum;

    assign xfer    = in_valid && in_ready;
    // One extra bit keeps the carry out of the accumulator for the sticky overflow flag.
    assign acc_sum = {1'b0, acc} + {{(ACC_W + 1 - 16){1'b0}}, mul_p};

    assign acc_out  = acc;
    assign overflow = ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            p_vld     <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; where the job-start clear below
            // also writes acc/ovf, the later assignment in this block takes effect.
            p_vld <= xfer;
            if (xfer) begin
                mul_a <= a;
                mul_b <= b;
            end
            if (p_vld) begin
                acc <= acc_sum[ACC_W-1:0];
                if (acc_sum[ACC_W]) begin
                    ovf <= 1'b1;
                end
            end

            // Handshake outputs are registered from the next state, so they always match it.
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        ovf       <= 1'b0;
                        busy      <= 1'b1;
                        remaining <= len;
                        if (len != '0) begin
                            state    <= RUN;
                            in_ready <= 1'b1;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == {{(LEN_W - 1){1'b0}}, 1'b1}) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // The last product is added at this edge through p_vld.
                    state     <= DONE;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wallace_mac_sequencer.sv
// Scoreboard bench for wallace_mac_sequencer: two instances (24-bit and 16-bit accumulators) share the stimulus,
// and expected sums come from plain integer arithmetic over each job's operand list.
module tb_wallace_mac_sequencer;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [7:0]       a;
    logic [7:0]       b;
    logic             out_ready;

    logic             in_ready, out_valid, overflow, busy;
    logic [7:0]       mul_a, mul_b;
    logic [15:0]      mul_p;
    logic [23:0]      acc_out;

    logic             in_ready_16, out_valid_16, overflow_16, busy_16;
    logic [7:0]       mul_a_16, mul_b_16;
    logic [15:0]      mul_p_16;
    logic [15:0]      acc_out_16;

    // Exact combinational multipliers stand in for the Wallace trees.
    assign mul_p    = 16'(mul_a) * 16'(mul_b);
    assign mul_p_16 = 16'(mul_a_16) * 16'(mul_b_16);

    always #5 clk = ~clk;

    wallace_mac_sequencer #(.ACC_W(24), .LEN_W(LEN_W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .overflow(overflow), .busy(busy)
    );

    wallace_mac_sequencer #(.ACC_W(16), .LEN_W(LEN_W)) u_dut16 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready_16), .a(a), .b(b),
        .mul_a(mul_a_16), .mul_b(mul_b_16), .mul_p(mul_p_16),
        .out_valid(out_valid_16), .out_ready(out_ready),
        .acc_out(acc_out_16), .overflow(overflow_16), .busy(busy_16)
    );

    typedef struct {
        logic [23:0] acc24;
        logic        ovf24;
        logic [15:0] acc16;
        logic        ovf16;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned job_a[$];
    int unsigned job_b[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the result is the plain sum of products, reduced modulo 2^W; overflow means the sum reached 2^W.
    function automatic exp_t model_job();
        longint unsigned sum;
        exp_t e;
        sum = 0;
        foreach (job_a[i]) sum += longint'(job_a[i]) * longint'(job_b[i]);
        e.acc24 = 24'(sum % (64'd1 << 24));
        e.ovf24 = (sum >= (64'd1 << 24));
        e.acc16 = 16'(sum % (64'd1 << 16));
        e.ovf16 = (sum >= (64'd1 << 16));
        return e;
    endfunction

    task automatic run_job(input int gap_min, input int gap_max, input int hold,
                           input bit start_in_run, input bit start_at_ack);
        exp_t            e;
        int              n;
        int              gap;
        longint unsigned partial;
        n       = job_a.size();
        partial = 0;
        e       = model_job();
        sb_q.push_back(e);

        start = 1'b1;
        len   = LEN_W'(n);
        step();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        if (n == 0) begin
            check("len0_done_next_cycle", out_valid, 1);
        end else begin
            check("in_ready_in_run", in_ready, 1);
            for (int i = 0; i < n; i++) begin
                gap = $urandom_range(gap_max, gap_min);
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    step();
                    check("in_ready_during_gap", in_ready, 1);
                    check("acc_stable_during_gap", acc_out, 32'(partial % (64'd1 << 24)));
                end
                in_valid = 1'b1;
                a = 8'(job_a[i]);
                b = 8'(job_b[i]);
                if (start_in_run && i == n / 2) begin
                    start = 1'b1;
                    len   = LEN_W'($urandom_range(255, 1));
                end
                check("in_ready_before_xfer", in_ready, 1);
                step();
                start = 1'b0;
                partial += longint'(job_a[i]) * longint'(job_b[i]);
            end
            in_valid = 1'b0;
            check("drain_out_valid_low", out_valid, 0);
            check("drain_in_ready_low", in_ready, 0);
            check("drain_busy", busy, 1);
            step();
        end
        check("done_out_valid", out_valid, 1);
        for (int h = 0; h < hold; h++) begin
            step();
            check("hold_out_valid", out_valid, 1);
            check("hold_acc_stable", acc_out, 32'(e.acc24));
            check("hold_ovf_stable", overflow, 32'(e.ovf24));
        end
        out_ready = 1'b1;
        if (start_at_ack) begin
            start = 1'b1;
            len   = LEN_W'(5);
        end
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        check("idle_out_valid_low", out_valid, 0);
        check("idle_busy_low", busy, 0);
        check("idle_busy16_low", busy_16, 0);
        job_a.delete();
        job_b.delete();
    endtask

    task automatic add_pair(input int unsigned pa, input int unsigned pb);
        job_a.push_back(pa);
        job_b.push_back(pb);
    endtask

    // Monitor: pops one expectation per accepted result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got acc %0d with no job outstanding", acc_out);
                end else begin
                    e = sb_q.pop_front();
                    check("acc_out_24", acc_out, 32'(e.acc24));
                    check("overflow_24", overflow, 32'(e.ovf24));
                    check("out_valid_16", out_valid_16, 1);
                    check("acc_out_16", acc_out_16, 32'(e.acc16));
                    check("overflow_16", overflow_16, 32'(e.ovf16));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit big;
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_acc_out", acc_out, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_mul_a", mul_a, 0);
        rst = 1'b0;
        step();

        // Back-to-back pairs: 12 + 100 + 255.
        add_pair(3, 4); add_pair(10, 10); add_pair(255, 1);
        run_job(0, 0, 0, 1'b0, 1'b0);

        // Three idle cycles before each pair: 56 + 4.
        add_pair(7, 8); add_pair(2, 2);
        run_job(3, 3, 0, 1'b0, 1'b0);

        // 130050 wraps a 16-bit accumulator to 64514.
        add_pair(255, 255); add_pair(255, 255);
        run_job(0, 1, 0, 1'b0, 1'b0);

        // Empty job with a stalled consumer.
        run_job(0, 0, 4, 1'b0, 1'b0);

        // Stray start pulses during RUN and in the acknowledge cycle.
        add_pair(11, 13); add_pair(200, 3); add_pair(9, 9); add_pair(1, 250);
        run_job(0, 1, 1, 1'b1, 1'b1);

        // Reset in the middle of a four-pair job.
        start = 1'b1;
        len   = LEN_W'(4);
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        a = 8'd9;  b = 8'd9;  step();
        a = 8'd20; b = 8'd30; step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_acc_out", acc_out, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_mul_b", mul_b, 0);
        check("midrst_in_ready16", in_ready_16, 0);
        #2 rst = 1'b0;
        add_pair(6, 6);
        run_job(0, 0, 0, 1'b0, 1'b0);

        // Randomized jobs; long jobs with large operands push the 16-bit instance into overflow.
        for (int j = 0; j < 30; j++) begin
            n   = ($urandom_range(3, 0) == 0) ? int'($urandom_range(40, 20)) : int'($urandom_range(10, 0));
            big = 1'($urandom_range(1, 0));
            for (int k = 0; k < n; k++) begin
                if (big) add_pair($urandom_range(255, 200), $urandom_range(255, 200));
                else     add_pair($urandom_range(255, 0), $urandom_range(255, 0));
            end
            run_job(0, int'($urandom_range(2, 0)), int'($urandom_range(2, 0)),
                    1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        for (int w = 0; w < 10 && sb_q.size() != 0; w++) step();
        check("scoreboard_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
